// File: rtl/vga_seq_pkg.sv
// vga_seq_pkg: shared constants, pattern enum and advance helper for the VGA pattern sequencer.
// Build option VGA_SEQ_GRADIENT_EN adds the gradient pattern (index 4).  Rev 1.0
`default_nettype none

package vga_seq_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int BAR_WIDTH        = 80;

  typedef enum logic [2:0] {
    PAT_EDGE  = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_CHECK = 3'd2,
    PAT_WHITE = 3'd3,
    PAT_GRAD  = 3'd4
  } pat_e;

`ifdef VGA_SEQ_GRADIENT_EN
  localparam int NUM_PATTERNS = 5;
`else
  localparam int NUM_PATTERNS = 4;
`endif

  localparam logic [2:0] LAST_PATTERN = 3'(NUM_PATTERNS - 1);

  function automatic logic [2:0] next_pattern(input logic [2:0] idx);
    return (idx == LAST_PATTERN) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: combinational map from (pattern_idx, hpos, vpos) to 2-bit RGB.
// Gradient pattern only built with VGA_SEQ_GRADIENT_EN.  Rev 1.0
`default_nettype none

module vga_pattern_gen
  import vga_seq_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic [2:0] pattern_idx,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  function automatic logic [1:0] edge_code(input logic [9:0] pos, input logic [9:0] last);
    if (pos == 10'd0)     return 2'b01;
    else if (pos < last)  return 2'b10;
    else                  return 2'b11;
  endfunction

  logic [2:0] bar;
  logic       check;

  always_comb begin
    r     = 2'b00;
    g     = 2'b00;
    b     = 2'b00;
    check = hpos[5] ^ vpos[5];
    // Bar index from threshold compares, avoiding a divider.
    bar   = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (hpos >= 10'(i * BAR_WIDTH)) bar = 3'(i);
    end

    case (pat_e'(pattern_idx))
      PAT_EDGE: begin
        r = edge_code(hpos, H_LAST);
        g = edge_code(vpos, V_LAST);
      end
      PAT_BARS: begin
        r = {2{bar[0]}};
        g = {2{bar[1]}};
        b = {2{bar[2]}};
      end
      PAT_CHECK: begin
        r = {2{check}};
        g = {2{check}};
        b = {2{check}};
      end
      PAT_WHITE: begin
        r = 2'b11;
        g = 2'b11;
        b = 2'b11;
      end
`ifdef VGA_SEQ_GRADIENT_EN
      PAT_GRAD: begin
        r = hpos[7:6];
        g = vpos[7:6];
        b = 2'b01;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: steps test patterns at frame boundaries (auto or manual) with registered, aligned RGB/sync.
// Build option VGA_SEQ_GRADIENT_EN selects 5 patterns instead of 4.  Rev 1.0
`default_nettype none

module vga_pattern_sequencer
  import vga_seq_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       advance,
  input  logic       auto_en,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [2:0] pattern_idx
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [9:0] V_TICK    = 10'(V_ACTIVE);

  logic       pending;
  logic [7:0] frame_cnt;

  logic       frame_tick;
  logic       take;
  logic       pending_next;
  logic [7:0] cnt_next;
  logic [2:0] idx_next;
  logic [1:0] pix_r, pix_g, pix_b;

  vga_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_gen (
    .pattern_idx (pattern_idx),
    .hpos        (hpos),
    .vpos        (vpos),
    .r           (pix_r),
    .g           (pix_g),
    .b           (pix_b)
  );

  always_comb begin
    frame_tick   = (vpos == V_TICK) && (hpos == 10'd0);
    // Manual and auto requests on the same tick merge into one step.
    take         = frame_tick && (pending || advance || (auto_en && (frame_cnt == HOLD_LAST)));
    pending_next = frame_tick ? 1'b0 : (pending | advance);
    idx_next     = take ? next_pattern(pattern_idx) : pattern_idx;
    cnt_next     = frame_cnt;
    if (!auto_en)        cnt_next = 8'd0;
    else if (take)       cnt_next = 8'd0;
    else if (frame_tick) cnt_next = frame_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      frame_cnt   <= 8'd0;
      pattern_idx <= 3'd0;
      R           <= 2'b00;
      G           <= 2'b00;
      B           <= 2'b00;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
    end else begin
      pending     <= pending_next;
      frame_cnt   <= cnt_next;
      pattern_idx <= idx_next;
      R           <= display_on ? pix_r : 2'b00;
      G           <= display_on ? pix_g : 2'b00;
      B           <= display_on ? pix_b : 2'b00;
      hsync_out   <= hsync_in;
      vsync_out   <= vsync_in;
    end
  end

endmodule

`default_nettype wire
